// File: rtl/mean_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed mean-neuron scheduler.
package mean_pkg;

    localparam int W                  = 20;
    localparam int N_IN               = 9;
    localparam int N_OUT              = 2;
    localparam int ENTRIES_PER_NEURON = N_IN + 1;
    localparam int ADDR_W             = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mean_acc.sv
// Gated signed accumulator: adds data when gate is set, and on the bias entry
// presents acc+bias on sum while clearing itself for the next neuron.
module mean_acc #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                absorb,
    input  logic                gate,
    input  logic                load,
    input  logic signed [W-1:0] data,
    output logic signed [W-1:0] sum
);

    logic signed [W-1:0] acc;
    logic signed [W-1:0] term;

    assign term = gate ? data : '0;
    assign sum  = acc + term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (absorb) begin
            acc <= load ? '0 : sum;
        end
    end

endmodule

// File: rtl/mean_scheduler.sv
// Streams N_OUT*(N_IN+1) weight/bias words from memory through one accumulator
// and publishes one signed mean-neuron result per neuron.
module mean_scheduler
    import mean_pkg::*;
#(
    parameter int W     = mean_pkg::W,
    parameter int N_IN  = mean_pkg::N_IN,
    parameter int N_OUT = mean_pkg::N_OUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_IN-1:0]     x_in,
    output logic                w_rd,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic signed [W-1:0] w_data,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] c_out0,
    output logic signed [W-1:0] c_out1
);

    localparam int EPN  = N_IN + 1;
    localparam int PW   = $clog2(EPN);
    localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int LAST = N_OUT * EPN - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST);
    localparam logic [PW-1:0]     BIAS_POS  = PW'(N_IN);

    state_t state, state_nxt;
    logic   accept;

    logic [ADDR_W-1:0] addr;
    logic [PW-1:0]     pos;
    logic [NW-1:0]     neu;
    logic [N_IN-1:0]   x_lat;

    // Read-issue stage delayed by one cycle: describes the word on w_data now.
    logic              pend;
    logic [PW-1:0]     pend_pos;
    logic [NW-1:0]     pend_neu;
    logic              pend_last;

    logic [EPN-1:0]      x_ext;
    logic                gate;
    logic                is_bias;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] c_reg [N_OUT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (addr == LAST_ADDR) state_nxt = FINISH;
            end
            FINISH: begin
                if (pend && pend_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign w_rd   = (state == RUN);
    assign w_addr = addr;
    assign busy   = (state != IDLE);

    // Address, in-neuron position and neuron index advance together so no multiply is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            pos   <= '0;
            neu   <= '0;
            x_lat <= '0;
        end else if (accept) begin
            addr  <= '0;
            pos   <= '0;
            neu   <= '0;
            x_lat <= x_in;
        end else if (state == RUN) begin
            if (addr == LAST_ADDR) begin
                addr <= '0;
                pos  <= '0;
                neu  <= '0;
            end else begin
                addr <= addr + 1'b1;
                if (pos == BIAS_POS) begin
                    pos <= '0;
                    neu <= neu + 1'b1;
                end else begin
                    pos <= pos + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_pos  <= '0;
            pend_neu  <= '0;
            pend_last <= 1'b0;
            done      <= 1'b0;
        end else begin
            pend      <= w_rd;
            pend_pos  <= pos;
            pend_neu  <= neu;
            pend_last <= w_rd && (addr == LAST_ADDR);
            done      <= (state == FINISH) && pend && pend_last;
        end
    end

    // Bias slot carries a forced-one select bit so the bias always adds.
    assign x_ext   = {1'b1, x_lat};
    assign gate    = x_ext[pend_pos];
    assign is_bias = (pend_pos == BIAS_POS);

    mean_acc #(.W(W)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .absorb (pend),
        .gate   (gate),
        .load   (is_bias),
        .data   (w_data),
        .sum    (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_OUT; n++) c_reg[n] <= '0;
        end else if (pend && is_bias) begin
            for (int n = 0; n < N_OUT; n++) begin
                if (pend_neu == NW'(n)) c_reg[n] <= sum;
            end
        end
    end

    assign c_out0 = c_reg[0];
    assign c_out1 = c_reg[1];

endmodule

// File: doc/mean_scheduler.md
MEAN_SCHEDULER -- requirements
Module: mean_scheduler

Interface
REQ-001 Parameter W, default 20, signed fixed-point data width for weights, bias and outputs.
REQ-002 Parameter N_IN, default 9, number of binary inputs per neuron.
REQ-003 Parameter N_OUT, default 2, number of mean neurons time-multiplexed on one accumulator.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high (clk, rst).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  request a computation; sampled only while idle.
REQ-008 x_in  in  N_IN  binary input vector; bit i is X_i.
REQ-009 w_rd  out  1  weight-memory read enable.
REQ-010 w_addr  out  5  weight-memory address, neuron*(N_IN+1)+k; k<N_IN weight, k=N_IN bias.
REQ-011 w_data  in  W  signed memory data, valid the cycle after the w_rd/w_addr cycle.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  one-cycle pulse when all outputs are updated.
REQ-014 c_out0, c_out1  out  W each  signed result of neuron 0 and neuron 1.

Function
REQ-015 Each neuron result SHALL be sum over i of (X_i ? Wm_i : 0) plus the bias, in two's complement modulo 2^W (wrap, no saturation).
REQ-016 FSM states SHALL be IDLE, RUN and FINISH; IDLE->RUN on start, RUN->FINISH after the last read is issued, FINISH->IDLE when the last datum is absorbed.
REQ-017 x_in SHALL be latched at the start edge (E0); later x_in changes SHALL not affect the run.
REQ-018 Address k (0..N_OUT*(N_IN+1)-1) SHALL be driven with w_rd=1 in the cycle after edge E_k, strictly incrementing, one per cycle.
REQ-019 Data for address k SHALL be absorbed at edge E_(k+2); weights add only when the latched X bit is 1; the bias always adds.
REQ-020 When a neuron's bias is absorbed, its c_out SHALL load acc+bias and the accumulator SHALL clear in the same edge.
REQ-021 For defaults, c_out0 SHALL update at E11, c_out1 at E21, done SHALL be high only in the cycle after E21, and busy SHALL fall at E21.
REQ-022 start while busy SHALL be ignored; start high in the done cycle SHALL be accepted (back-to-back run, E0 = that edge).
REQ-023 c_out0/c_out1 SHALL hold their values between runs and change only per REQ-020.
REQ-024 w_rd SHALL be 0 and w_addr SHALL hold 0 while IDLE or FINISH.

Reset
REQ-025 rst SHALL force IDLE, and busy, done, w_rd, w_addr, accumulator, latched x, c_out0 and c_out1 to 0 immediately.
REQ-026 Reset mid-run SHALL abort without any output update; the next start SHALL run fully from address 0.

Structure
REQ-027 Package mean_pkg SHALL hold W, N_IN, N_OUT, ENTRIES_PER_NEURON (N_IN+1) and the FSM state enum.
REQ-028 One sub-module, mean_acc (W-bit gated accumulator with clear and load-out), SHALL hold the arithmetic; the FSM and counters stay in mean_scheduler.

Verification
REQ-029 Reset: assert rst mid-cycle -> all outputs 0 asynchronously, before the next clk edge.
REQ-030 mem[0..8]=20'sh00001, mem[9]=20'sh00010, mem[10..18]=20'shFFFFF, mem[19]=0, x_in=9'h1FF -> c_out0=20'sh00019, c_out1=20'shFFFF7, done 21 edges after start.
REQ-031 Same memory, x_in=9'h000 -> c_out0=20'sh00010, c_out1=20'sh00000.
REQ-032 mem[0]=mem[1]=20'sh7FFFF, other neuron-0 entries 0, x_in=9'h003 -> c_out0=20'shFFFFE (wrap).
REQ-033 start pulsed at E5 and x_in toggled mid-run -> no restart, results match the latched x; start in the done cycle -> second run done 21 edges later.
REQ-034 rst at E10 of a run -> c_out0/c_out1 = 0, busy 0, no done; the next run yields REQ-030 values.
